// File: rtl/regfile_dump_if.sv
// Output word stream of the register-file dump engine.
// The engine drives valid/data/idx and the consumer drives ready.
interface regfile_dump_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] data;
    logic [AW-1:0]   idx;

    modport master (
        output valid,
        output data,
        output idx,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  idx,
        output ready
    );
endinterface

// File: rtl/regfile_dump.sv
// Debug read-out engine for the 32 x 64-bit register file.
// It walks an inclusive index range and reads the file through a spare
// read port, then emits each value on a valid/ready stream tagged with
// its index. It never writes the register file.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for start; rf_ra parked at 0
//  READ  | rf_ra = idx, capture rf_rd into the output word (1 cycle)
//  HOLD  | word valid and stable until the consumer takes it
//  DONE  | one-cycle done pulse, then back to IDLE
module regfile_dump #(
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [AW-1:0]    first,
    input  logic [AW-1:0]    last,
    output logic [AW-1:0]    rf_ra,
    input  logic [XLEN-1:0]  rf_rd,
    output logic             busy,
    output logic             done,
    regfile_dump_if.master   stream
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   last_q;
    logic            out_valid;
    logic [XLEN-1:0] out_data;
    logic [AW-1:0]   out_idx;

    // The index counter is the read address; it is held at 0 whenever idle.
    assign rf_ra        = idx;
    assign stream.valid = out_valid;
    assign stream.data  = out_data;
    assign stream.idx   = out_idx;

    // Sequencer: range walk, word capture/handshake, abort and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            last_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                // A word pending in HOLD is dropped, not delivered.
                state     <= IDLE;
                idx       <= '0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            last_q <= last;
                            busy   <= 1'b1;
                            if (first <= last) begin
                                idx   <= first;
                                state <= READ;
                            end else begin
                                // Empty range: complete without emitting a word.
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        out_data  <= rf_rd;
                        out_idx   <= idx;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                    HOLD: begin
                        if (stream.ready) begin
                            out_valid <= 1'b0;
                            // Stop on the last index before incrementing so
                            // last = 31 never wraps the counter back to 0.
                            if (idx == last_q) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= READ;
                            end
                        end
                    end
                    DONE: begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        idx       <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural register file answers the read
// port, directed dumps push the expected words into a queue, and a
// monitor pops and compares each word as it is handed over.
module tb_regfile_dump;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    typedef struct {
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data;
    } exp_t;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic            abort;
    logic [AW-1:0]   first;
    logic [AW-1:0]   last;
    logic [AW-1:0]   rf_ra;
    logic [XLEN-1:0] rf_rd;
    logic            busy;
    logic            done;

    logic [XLEN-1:0] rf [32];

    regfile_dump_if #(.XLEN(XLEN), .AW(AW)) sif ();

    regfile_dump #(.XLEN(XLEN), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .abort   (abort),
        .first   (first),
        .last    (last),
        .rf_ra   (rf_ra),
        .rf_rd   (rf_rd),
        .busy    (busy),
        .done    (done),
        .stream  (sif)
    );

    exp_t exp_q[$];
    int   checks      = 0;
    int   failures    = 0;
    int   cycle       = 0;
    int   done_cnt    = 0;
    int   done_cyc    = 0;
    int   valid_cnt   = 0;
    int   start_cyc   = 0;
    int   done_before = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // X31 is the zero register: it always reads 0.
    always_comb begin
        rf_rd = '0;
        if (rf_ra != 5'd31) rf_rd = rf[rf_ra];
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: word handshakes and done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (sif.valid) valid_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cycle;
        end
        if (reset_n && sif.valid && sif.ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word: got idx %0d data %0h expected no word", sif.idx, sif.data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (sif.idx !== e.idx || sif.data !== e.data) begin
                    failures++;
                    $display("FAIL word: got idx %0d data %0h expected idx %0d data %0h",
                             sif.idx, sif.data, e.idx, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int i, input logic [XLEN-1:0] d);
        exp_t e;
        e.idx  = AW'(i);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Expected words for a dump of the initial file image (Xn = n, X31 = 0).
    task automatic push_range(input int f, input int l);
        for (int i = f; i <= l; i++) push_word(i, (i == 31) ? 64'd0 : 64'(i));
    endtask

    task automatic issue(input int f, input int l);
        done_before = done_cnt;
        first       = AW'(f);
        last        = AW'(l);
        start       = 1'b1;
        start_cyc   = cycle;
        step();
        start = 1'b0;
        first = AW'(0);
        last  = AW'(0);
    endtask

    task automatic wait_done(input string name, input int max_cyc, output int lat);
        int n;
        n   = 0;
        lat = -1;
        while (done_cnt == done_before && n < max_cyc) begin
            step();
            n++;
        end
        checks++;
        if (done_cnt == done_before) begin
            failures++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, max_cyc);
        end else begin
            lat = done_cyc - start_cyc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;
        int d0;
        int v0;

        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        first     = '0;
        last      = '0;
        sif.ready = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 64'(i);
        step();
        step();

        check("rst_rf_ra", 64'(rf_ra), 64'd0);
        check("rst_valid", 64'(sif.valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", sif.data, 64'd0);
        reset_n = 1'b1;
        step();

        // 1: full dump 0..30 with ready tied high.
        push_range(0, 30);
        issue(0, 30);
        wait_done("t1", 200, lat);
        check("t1_latency", 64'(lat), 64'd63);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
        step();
        step();
        check("t1_one_done", 64'(done_cnt - done_before), 64'd1);
        check("t1_busy_low", 64'(busy), 64'd0);
        check("t1_rf_ra_idle", 64'(rf_ra), 64'd0);

        // 2: range reaching X31 must stop there without wrapping.
        push_range(29, 31);
        issue(29, 31);
        wait_done("t2", 50, lat);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        v0 = valid_cnt;
        step();
        step();
        step();
        check("t2_no_wrap", 64'(valid_cnt - v0), 64'd0);

        // 3: single word stalled by the consumer for 10 cycles.
        sif.ready = 1'b0;
        push_range(5, 5);
        issue(5, 5);
        step();
        check("t3_first_valid", 64'(sif.valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 64'(sif.valid), 64'd1);
            check("t3_hold_data", sif.data, 64'd5);
        end
        @(posedge clk);
        #1;
        sif.ready = 1'b1;
        wait_done("t3", 20, lat);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        step();

        // 4: empty range emits nothing and completes immediately.
        v0 = valid_cnt;
        issue(7, 3);
        wait_done("t4", 10, lat);
        check("t4_latency", 64'(lat), 64'd1);
        check("t4_no_word", 64'(valid_cnt - v0), 64'd0);
        step();

        // 5: abort while word 12 is held; it is discarded.
        push_range(10, 11);
        issue(10, 20);
        n = 0;
        while (!(sif.valid && sif.idx == 5'd12) && n < 40) begin
            step();
            n++;
        end
        check("t5_reach_idx12", 64'(sif.valid && sif.idx == 5'd12), 64'd1);
        sif.ready = 1'b0;
        abort     = 1'b1;
        d0        = done_cnt;
        step();
        abort     = 1'b0;
        sif.ready = 1'b1;
        @(negedge clk);
        check("t5_valid_dropped", 64'(sif.valid), 64'd0);
        check("t5_busy_dropped", 64'(busy), 64'd0);
        step();
        step();
        step();
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        push_range(12, 12);
        issue(12, 12);
        wait_done("t5_restart", 20, lat);
        check("t5_restart_queue", 64'(exp_q.size()), 64'd0);
        step();

        // 6: X4 rewritten before index 4 is read; the dump sees the new value.
        push_range(0, 3);
        push_word(4, 64'hDEAD);
        push_range(5, 8);
        issue(0, 8);
        rf[4] = 64'hDEAD;
        wait_done("t6", 50, lat);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        rf[4] = 64'd4;
        step();

        // 6b: asynchronous reset in the middle of a dump.
        push_range(0, 30);
        issue(0, 30);
        for (int i = 0; i < 6; i++) step();
        #2;
        d0      = done_cnt;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(sif.valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_rf_ra", 64'(rf_ra), 64'd0);
        check("t6_rst_data", sif.data, 64'd0);
        check("t6_rst_idx", 64'(sif.idx), 64'd0);
        exp_q.delete();
        step();
        reset_n = 1'b1;
        step();
        step();
        check("t6_rst_no_done", 64'(done_cnt - d0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
